stream_video_tpg: RTL and testbench

- AXI4-Stream video test pattern generator. It sits directly upstream of the line-buffer window filter and drives its s_axis_video_* port.
- It produces complete frames of IMG_WIDTH x IMG_HEIGHT 24-bit pixels, with tuser marking start of frame (SOF) and tlast marking end of line (EOL).
- It inserts programmable blanking gaps so the filter's copy-first, copy-last and end-of-line cycles are exercised without a backpressuring source.

---
 rtl/video_pkg.sv | 33 +++
 rtl/tpg_pixel_gen.sv | 69 ++++++
 rtl/stream_video_tpg.sv | 197 +++++++++++++++++++
 tb/tb_stream_video_tpg.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared video-stream definitions: pixel layout, pattern codes, colour-bar table
// and test-pattern-generator state encodings.
package video_pkg;

  localparam int PIX_W   = 24;
  localparam int CH_W    = 8;
  localparam int CH0_LSB = 0;
  localparam int CH1_LSB = 8;
  localparam int CH2_LSB = 16;

  localparam logic [1:0] PAT_COORD   = 2'd0;
  localparam logic [1:0] PAT_RAMP    = 2'd1;
  localparam logic [1:0] PAT_BARS    = 2'd2;
  localparam logic [1:0] PAT_CHECKER = 2'd3;

  localparam logic [PIX_W-1:0] BAR_COLORS [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HGAP   = 2'd2,
    ST_VGAP   = 2'd3
  } tpg_state_e;

  // First column whose bar index reaches k, i.e. ceil(k*width/8); elaboration-time only.
  function automatic int bar_threshold(input int k, input int width);
    return (k * width + 7) / 8;
  endfunction

endpackage

// File: rtl/tpg_pixel_gen.sv
// Registered pixel function of (col, line, frame, pattern); loads only when the
// next beat is committed so the output stays stable under backpressure.
module tpg_pixel_gen
  import video_pkg::*;
#(
  parameter int IMG_WIDTH  = 20,
  parameter int CHECK_LOG2 = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [7:0]       i_col,
  input  logic [7:0]       i_line,
  input  logic [7:0]       i_frame,
  input  logic [1:0]       i_pat,
  output logic [PIX_W-1:0] o_pix
);

  logic [2:0]       w_bar_idx;
  logic             w_chk_bit;
  logic [PIX_W-1:0] w_pix;
  logic [PIX_W-1:0] r_pix;

  // Bar index = (col*8)/IMG_WIDTH via constant thresholds; the last threshold passed wins
  always_comb begin
    w_bar_idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (i_col >= 8'(bar_threshold(k, IMG_WIDTH))) begin
        w_bar_idx = 3'(k);
      end else begin
        w_bar_idx = w_bar_idx;
      end
    end
  end

  assign w_chk_bit = i_col[CHECK_LOG2] ^ i_line[CHECK_LOG2] ^ i_frame[0];

  // Pattern multiplexer
  always_comb begin
    w_pix = {PIX_W{1'b0}};
    case (i_pat)
      PAT_COORD: begin
        w_pix[CH2_LSB +: CH_W] = i_frame;
        w_pix[CH1_LSB +: CH_W] = i_line;
        w_pix[CH0_LSB +: CH_W] = i_col;
      end
      PAT_RAMP: begin
        w_pix[CH2_LSB +: CH_W] = i_col;
        w_pix[CH1_LSB +: CH_W] = i_col;
        w_pix[CH0_LSB +: CH_W] = i_col;
      end
      PAT_BARS:    w_pix = BAR_COLORS[w_bar_idx];
      PAT_CHECKER: w_pix = w_chk_bit ? {PIX_W{1'b1}} : {PIX_W{1'b0}};
      default:     w_pix = {PIX_W{1'b0}};
    endcase
  end

  // Pixel register
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pix <= {PIX_W{1'b0}};
    end else if (i_load) begin
      r_pix <= w_pix;
    end
  end

  assign o_pix = r_pix;

endmodule

// File: rtl/stream_video_tpg.sv
// AXI4-Stream video test pattern generator: whole frames with SOF on tuser, EOL on
// tlast, and programmable idle gaps after each line and each frame.
module stream_video_tpg
  import video_pkg::*;
#(
  parameter int IMG_WIDTH  = 20,
  parameter int IMG_HEIGHT = 16,
  parameter int H_GAP      = 2,
  parameter int V_GAP      = 4,
  parameter int CHECK_LOG2 = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       pattern_sel,
  output logic [PIX_W-1:0] m_axis_video_tdata,
  output logic             m_axis_video_tvalid,
  input  logic             m_axis_video_tready,
  output logic             m_axis_video_tuser,
  output logic             m_axis_video_tlast,
  output logic [7:0]       frame_cnt,
  output logic             busy
);

  localparam int            GW        = 16;
  localparam int            GAP_TOT   = H_GAP + V_GAP;
  localparam logic [7:0]    COL_LAST  = 8'(IMG_WIDTH - 1);
  localparam logic [7:0]    LINE_LAST = 8'(IMG_HEIGHT - 1);
  localparam logic [GW-1:0] HGAP_LAST = GW'(H_GAP - 1);
  localparam logic [GW-1:0] VGAP_LAST = GW'(GAP_TOT - 1);

  tpg_state_e    r_state, w_state_nxt;
  logic [7:0]    r_col, w_col_nxt;
  logic [7:0]    r_line, w_line_nxt;
  logic [7:0]    r_frame_cnt, w_frame_nxt;
  logic [GW-1:0] r_gap, w_gap_nxt;
  logic [1:0]    r_pat, w_pat_nxt;
  logic          r_valid, w_valid_nxt;
  logic          r_user, w_user_nxt;
  logic          r_last, w_last_nxt;
  logic          r_busy;
  logic          w_load;
  logic          w_txf;

  assign w_txf = r_valid & m_axis_video_tready;

  // Next-state, counter and beat-launch logic; a new beat is loaded only after the previous one transferred
  always_comb begin
    w_state_nxt = r_state;
    w_col_nxt   = r_col;
    w_line_nxt  = r_line;
    w_frame_nxt = r_frame_cnt;
    w_gap_nxt   = r_gap;
    w_pat_nxt   = r_pat;
    w_valid_nxt = r_valid;
    w_user_nxt  = r_user;
    w_last_nxt  = r_last;
    w_load      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (enable) begin
          w_state_nxt = ST_ACTIVE;
          w_pat_nxt   = pattern_sel;
          w_col_nxt   = 8'd0;
          w_line_nxt  = 8'd0;
          w_load      = 1'b1;
          w_valid_nxt = 1'b1;
          w_user_nxt  = 1'b1;
          w_last_nxt  = (COL_LAST == 8'd0);
        end else begin
          w_valid_nxt = 1'b0;
        end
      end
      ST_ACTIVE: begin
        if (!w_txf) begin
          w_valid_nxt = r_valid;
        end else if (r_col != COL_LAST) begin
          w_col_nxt  = r_col + 8'd1;
          w_load     = 1'b1;
          w_user_nxt = 1'b0;
          w_last_nxt = ((r_col + 8'd1) == COL_LAST);
        end else if (r_line != LINE_LAST) begin
          w_col_nxt  = 8'd0;
          w_line_nxt = r_line + 8'd1;
          w_load     = 1'b1;
          w_user_nxt = 1'b0;
          w_last_nxt = 1'b0;
          if (H_GAP > 0) begin
            w_state_nxt = ST_HGAP;
            w_valid_nxt = 1'b0;
            w_gap_nxt   = {GW{1'b0}};
          end else begin
            w_valid_nxt = 1'b1;
          end
        end else begin
          w_col_nxt   = 8'd0;
          w_line_nxt  = 8'd0;
          w_frame_nxt = r_frame_cnt + 8'd1;
          w_user_nxt  = 1'b0;
          w_last_nxt  = 1'b0;
          if (GAP_TOT > 0) begin
            w_state_nxt = ST_VGAP;
            w_valid_nxt = 1'b0;
            w_gap_nxt   = {GW{1'b0}};
          end else if (enable) begin
            // Zero-length frame gap: next SOF launches on the same edge
            w_pat_nxt   = pattern_sel;
            w_load      = 1'b1;
            w_user_nxt  = 1'b1;
            w_valid_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
            w_valid_nxt = 1'b0;
          end
        end
      end
      ST_HGAP: begin
        if (r_gap == HGAP_LAST) begin
          w_state_nxt = ST_ACTIVE;
          w_valid_nxt = 1'b1;
          w_gap_nxt   = {GW{1'b0}};
        end else begin
          w_gap_nxt = r_gap + 16'd1;
        end
      end
      ST_VGAP: begin
        if (r_gap != VGAP_LAST) begin
          w_gap_nxt = r_gap + 16'd1;
        end else if (enable) begin
          w_gap_nxt   = {GW{1'b0}};
          w_state_nxt = ST_ACTIVE;
          w_pat_nxt   = pattern_sel;
          w_load      = 1'b1;
          w_valid_nxt = 1'b1;
          w_user_nxt  = 1'b1;
          w_last_nxt  = 1'b0;
        end else begin
          w_gap_nxt   = {GW{1'b0}};
          w_state_nxt = ST_IDLE;
          w_valid_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  // State, counters and registered stream outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_col       <= 8'd0;
      r_line      <= 8'd0;
      r_frame_cnt <= 8'd0;
      r_gap       <= {GW{1'b0}};
      r_pat       <= PAT_COORD;
      r_valid     <= 1'b0;
      r_user      <= 1'b0;
      r_last      <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_col       <= w_col_nxt;
      r_line      <= w_line_nxt;
      r_frame_cnt <= w_frame_nxt;
      r_gap       <= w_gap_nxt;
      r_pat       <= w_pat_nxt;
      r_valid     <= w_valid_nxt;
      r_user      <= w_user_nxt;
      r_last      <= w_last_nxt;
      r_busy      <= (w_state_nxt != ST_IDLE);
    end
  end

  tpg_pixel_gen #(
    .IMG_WIDTH  (IMG_WIDTH),
    .CHECK_LOG2 (CHECK_LOG2)
  ) u_pixel_gen (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_load),
    .i_col   (w_col_nxt),
    .i_line  (w_line_nxt),
    .i_frame (w_frame_nxt),
    .i_pat   (w_pat_nxt),
    .o_pix   (m_axis_video_tdata)
  );

  assign m_axis_video_tvalid = r_valid;
  assign m_axis_video_tuser  = r_user;
  assign m_axis_video_tlast  = r_last;
  assign frame_cnt           = r_frame_cnt;
  assign busy                = r_busy;

endmodule

// File: tb/tb_stream_video_tpg.sv
// Bench for stream_video_tpg: two configurations checked every cycle against a
// frame-level model, plus hand-computed beat values.
`timescale 1ns/1ps
module tb_stream_video_tpg;

  localparam int PH_WAIT = 0;
  localparam int PH_BEAT = 1;
  localparam int PH_GAP  = 2;

  logic        clk;
  logic        a_rst, a_en, a_rdy, a_valid, a_user, a_last, a_busy;
  logic [1:0]  a_pat;
  logic [23:0] a_data;
  logic [7:0]  a_fc;
  logic        b_rst, b_en, b_rdy, b_valid, b_user, b_last, b_busy;
  logic [1:0]  b_pat;
  logic [23:0] b_data;
  logic [7:0]  b_fc;
  bit          a_rnd;

  int checks;
  int failures;

  int         m_phase [2];
  int         m_gap   [2];
  int         m_col   [2];
  int         m_line  [2];
  int         m_frame [2];
  logic [1:0] m_pat   [2];
  bit         m_endf  [2];
  bit         m_zero  [2];
  bit         m_armed [2];
  logic [25:0] log_a [$];
  logic [25:0] log_b [$];

  // A: 4x3, no gaps.  B: 16x3, line gap 2, frame gap 2+3.
  stream_video_tpg #(.IMG_WIDTH(4), .IMG_HEIGHT(3), .H_GAP(0), .V_GAP(0), .CHECK_LOG2(2)) u_dut_a (
    .clk(clk), .reset(a_rst), .enable(a_en), .pattern_sel(a_pat),
    .m_axis_video_tdata(a_data), .m_axis_video_tvalid(a_valid), .m_axis_video_tready(a_rdy),
    .m_axis_video_tuser(a_user), .m_axis_video_tlast(a_last), .frame_cnt(a_fc), .busy(a_busy));

  stream_video_tpg #(.IMG_WIDTH(16), .IMG_HEIGHT(3), .H_GAP(2), .V_GAP(3), .CHECK_LOG2(2)) u_dut_b (
    .clk(clk), .reset(b_rst), .enable(b_en), .pattern_sel(b_pat),
    .m_axis_video_tdata(b_data), .m_axis_video_tvalid(b_valid), .m_axis_video_tready(b_rdy),
    .m_axis_video_tuser(b_user), .m_axis_video_tlast(b_last), .frame_cnt(b_fc), .busy(b_busy));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d got=%0h want=%0h", name, g, act, exp);
    end
  endtask

  function automatic logic [23:0] exp_pix(input int w, input int col, input int line, input int frame,
                                          input logic [1:0] pat);
    logic [23:0] r;
    case (pat)
      2'd0: r = {8'(frame), 8'(line), 8'(col)};
      2'd1: r = {8'(col), 8'(col), 8'(col)};
      2'd2: begin
        case ((col * 8) / w)
          0:       r = 24'hFFFFFF;
          1:       r = 24'hFFFF00;
          2:       r = 24'h00FFFF;
          3:       r = 24'h00FF00;
          4:       r = 24'hFF00FF;
          5:       r = 24'hFF0000;
          6:       r = 24'h0000FF;
          default: r = 24'h000000;
        endcase
      end
      default: r = ((((col >> 2) ^ (line >> 2) ^ frame) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
    endcase
    return r;
  endfunction

  // Check outputs against the model, then advance the model with the inputs the next edge will see.
  task automatic model_step(input int g, input logic [23:0] d, input logic v, input logic u, input logic l,
                            input logic [7:0] fc, input logic bsy, input logic rdy, input logic en,
                            input logic rst, input logic [1:0] ps);
    int w, hg, gt;
    bit beat;
    w  = (g == 0) ? 4 : 16;
    hg = (g == 0) ? 0 : 2;
    gt = (g == 0) ? 0 : 5;
    if (m_armed[g]) begin
      if (m_zero[g]) begin
        check("reset_outputs", g, {d, v, u, l}, 32'd0);
        check("reset_frame_cnt", g, fc, 32'd0);
        check("reset_busy", g, bsy, 32'd0);
      end else begin
        beat = (m_phase[g] == PH_BEAT);
        check("tvalid", g, v, beat);
        check("busy", g, bsy, m_phase[g] != PH_WAIT);
        check("frame_cnt", g, fc, m_frame[g]);
        if (beat) begin
          check("tdata", g, d, exp_pix(w, m_col[g], m_line[g], m_frame[g], m_pat[g]));
          check("tuser", g, u, (m_col[g] == 0) && (m_line[g] == 0));
          check("tlast", g, l, m_col[g] == w - 1);
        end
      end
      if (v && rdy && rst) begin
        if (g == 0) log_a.push_back({u, l, d});
        else        log_b.push_back({u, l, d});
      end
    end
    if (!rst) begin
      m_phase[g] = PH_WAIT; m_frame[g] = 0; m_col[g] = 0; m_line[g] = 0; m_gap[g] = 0;
      m_zero[g] = 1'b1; m_armed[g] = 1'b1;
    end else begin
      m_zero[g] = 1'b0;
      case (m_phase[g])
        PH_WAIT: begin
          if (en) begin
            m_phase[g] = PH_BEAT; m_col[g] = 0; m_line[g] = 0; m_pat[g] = ps;
          end
        end
        PH_BEAT: begin
          if (rdy) begin
            if (m_col[g] < w - 1) begin
              m_col[g]++;
            end else begin
              m_col[g] = 0;
              if (m_line[g] < 2) begin
                m_line[g]++;
                if (hg > 0) begin m_phase[g] = PH_GAP; m_gap[g] = hg; m_endf[g] = 1'b0; end
              end else begin
                m_line[g]  = 0;
                m_frame[g] = (m_frame[g] + 1) % 256;
                if (gt > 0) begin m_phase[g] = PH_GAP; m_gap[g] = gt; m_endf[g] = 1'b1; end
                else if (en) m_pat[g] = ps;
                else         m_phase[g] = PH_WAIT;
              end
            end
          end
        end
        PH_GAP: begin
          m_gap[g]--;
          if (m_gap[g] == 0) begin
            if (!m_endf[g]) m_phase[g] = PH_BEAT;
            else if (en) begin m_phase[g] = PH_BEAT; m_pat[g] = ps; end
            else m_phase[g] = PH_WAIT;
          end
        end
        default: m_phase[g] = PH_WAIT;
      endcase
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_step(0, a_data, a_valid, a_user, a_last, a_fc, a_busy, a_rdy, a_en, a_rst, a_pat);
    model_step(1, b_data, b_valid, b_user, b_last, b_fc, b_busy, b_rdy, b_en, b_rst, b_pat);
    @(posedge clk);
    #1;
    if (a_rnd) a_rdy = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_beats(input int g, input int n);
    int t;
    t = 0;
    while ((((g == 0) ? log_a.size() : log_b.size()) < n) && (t < 2000)) begin
      tick();
      t++;
    end
    check("beat_wait", g, (((g == 0) ? log_a.size() : log_b.size()) >= n), 32'd1);
  endtask

  task automatic count_low(input int g, output int n);
    n = 0;
    while ((((g == 0) ? a_valid : b_valid) == 1'b0) && (n < 50)) begin
      n++;
      tick();
    end
  endtask

  initial begin
    int n;
    checks = 0; failures = 0;
    a_rst = 1'b0; a_en = 1'b0; a_rdy = 1'b1; a_pat = 2'd0; a_rnd = 1'b0;
    b_rst = 1'b0; b_en = 1'b0; b_rdy = 1'b1; b_pat = 2'd0;
    for (int g = 0; g < 2; g++) begin
      m_phase[g] = PH_WAIT; m_gap[g] = 0; m_col[g] = 0; m_line[g] = 0; m_frame[g] = 0;
      m_pat[g] = 2'd0; m_endf[g] = 1'b0; m_zero[g] = 1'b0; m_armed[g] = 1'b0;
    end
    repeat (3) tick();
    a_rst = 1'b1; b_rst = 1'b1;
    tick();
    check("idle_tvalid", 0, a_valid, 32'd0);
    check("idle_busy", 1, b_busy, 32'd0);

    // Coordinate pattern, back-to-back lines and frames
    a_en = 1'b1;
    tick();
    check("start_latency", 0, {a_valid, a_user}, 32'd3);
    wait_beats(0, 13);
    check("beat1_sof", 0, log_a[0], {2'b10, 24'h000000});
    check("beat5", 0, log_a[4], {2'b00, 24'h000100});
    check("beat4_tlast", 0, log_a[3], {2'b01, 24'h000003});
    check("beat8_tlast", 0, log_a[7], {2'b01, 24'h000103});
    check("beat12_tlast", 0, log_a[11], {2'b01, 24'h000203});
    check("frame_cnt_1", 0, a_fc, 32'd1);
    check("next_sof", 0, log_a[12], {2'b10, 24'h010000});

    // Ramp under random backpressure; selector change waits for the next SOF
    a_pat = 2'd1; a_rnd = 1'b1;
    wait_beats(0, 36);
    check("pat_held_midframe", 0, log_a[13], {2'b00, 24'h010001});
    check("ramp_c0", 0, log_a[24], {2'b10, 24'h000000});
    check("ramp_c1", 0, log_a[25], {2'b00, 24'h010101});
    check("ramp_c3", 0, log_a[27], {2'b01, 24'h030303});
    check("ramp_l2c2", 0, log_a[34], {2'b00, 24'h020202});

    // Enable dropped on line 1: frame completes, then idle
    wait_beats(0, 41);
    a_en = 1'b0;
    wait_beats(0, 48);
    repeat (8) tick();
    check("no_extra_beats", 0, log_a.size(), 32'd48);
    check("stop_idle", 0, {a_busy, a_valid}, 32'd0);
    check("stop_frame_cnt", 0, a_fc, 32'd4);
    a_rnd = 1'b0; a_rdy = 1'b1;

    // Colour bars with line and frame gaps
    b_pat = 2'd2; b_en = 1'b1;
    wait_beats(1, 16);
    count_low(1, n);
    check("hgap_len", 1, n, 32'd2);
    check("bars_c0", 1, log_b[0], {2'b10, 24'hFFFFFF});
    check("bars_c2", 1, log_b[2], {2'b00, 24'hFFFF00});
    check("bars_c8", 1, log_b[8], {2'b00, 24'hFF00FF});
    check("bars_c15", 1, log_b[15], {2'b01, 24'h000000});
    wait_beats(1, 21);
    b_pat = 2'd3;
    wait_beats(1, 48);
    count_low(1, n);
    check("vgap_len", 1, n, 32'd5);
    check("bars_after_sel", 1, log_b[20], {2'b00, 24'h00FFFF});
    wait_beats(1, 53);
    check("checker_sof", 1, log_b[48], {2'b10, 24'hFFFFFF});
    check("checker_c4", 1, log_b[52], {2'b00, 24'h000000});

    // One-cycle reset inside a line gap
    wait_beats(1, 64);
    check("in_hgap", 1, {b_busy, b_valid}, 32'd2);
    b_rst = 1'b0;
    tick();
    check("rst_hgap_tvalid", 1, b_valid, 32'd0);
    check("rst_hgap_frame", 1, b_fc, 32'd0);
    b_rst = 1'b1;
    tick();
    check("restart_sof", 1, {b_valid, b_user, b_data}, {2'b11, 24'h000000});
    wait_beats(1, 66);
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
